// File: rtl/mem_pkg.sv
// Shared SRAM geometry for the switch memory subsystem.
// Combinational only: constants, no logic.
// No flow control: sizes only.
package mem_pkg;

    localparam int ADDR_W     = 10;
    localparam int BLOCK_BITS = 32;

endpackage

// File: rtl/switch_pkg.sv
// Switch-wide port indexing and arbitration defaults.
// Combinational only: constants and types, no logic.
// No flow control: types only.
package switch_pkg;

    localparam int MAX_PORTS    = 16;
    localparam int PORT_IDX_W   = 4;
    localparam int WEIGHT_W_DEF = 4;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with head peek, any depth >= 2.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full_o/empty_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Next pointers wrap at DEPTH (depth need not be a power of two); count tracks push-minus-pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wrr_sel.sv
// Weighted round-robin selector: owner pointer keeps the grant while it has credit.
// Latency: grant is combinational from req_i and registered ptr/credit.
// Backpressure: en_i low masks all requests, so no grant and state holds.
module wrr_sel
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = WEIGHT_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en_i,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0]  weight_i,
    output logic [NUM_PORTS-1:0]                gnt_o
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic [NUM_PORTS-1:0] req_eff;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     cand;
    logic                 gnt_vld;
    logic                 found;

    assign req_eff = req_i & {NUM_PORTS{en_i}};
    assign gnt_o   = gnt_vld ? (NUM_PORTS'(1) << gnt_idx) : '0;

    // Owner keeps the slot while credit lasts; otherwise scan ptr+1..ptr (ptr last) and reload credit.
    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = '0;
        if (req_eff[ptr_q] && (credit_q != '0)) begin
            gnt_vld  = 1'b1;
            gnt_idx  = ptr_q;
            credit_d = credit_q - 1'b1;
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
                if (!found && req_eff[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (found) begin
                gnt_vld  = 1'b1;
                ptr_d    = gnt_idx;
                // Weight 0 is treated as weight 1: one grant, no extra credit.
                credit_d = (weight_i[gnt_idx] == '0) ? '0 : weight_i[gnt_idx] - 1'b1;
            end
        end
    end

    // Reset points at the last port so port 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= PTR_W'(NUM_PORTS - 1);
            credit_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates per-port read/write requests onto one SRAM port pair and routes read data back by tag.
// Latency: write/read command 1 cycle after grant; read data 1 cycle after mem_rvalid_i.
// Backpressure: read grants stall while the tag FIFO (RD_LAT+2 deep) is full; writes never stall.
module mem_port_arbiter
    import mem_pkg::*;
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int RD_LAT    = 1,
    parameter int WEIGHT_W  = WEIGHT_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0]   wr_weight_i,
    input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0]   rd_weight_i,
    input  logic [NUM_PORTS-1:0]                 wr_req_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     wr_addr_i,
    input  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0] wr_data_i,
    output logic [NUM_PORTS-1:0]                 wr_gnt_o,
    output logic                                 mem_we_o,
    output logic [ADDR_W-1:0]                    mem_waddr_o,
    output logic [BLOCK_BITS-1:0]                mem_wdata_o,
    input  logic [NUM_PORTS-1:0]                 rd_req_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     rd_addr_i,
    output logic [NUM_PORTS-1:0]                 rd_gnt_o,
    output logic                                 mem_re_o,
    output logic [ADDR_W-1:0]                    mem_raddr_o,
    input  logic                                 mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0]                mem_rdata_i,
    output logic [NUM_PORTS-1:0]                 rd_valid_o,
    output logic [BLOCK_BITS-1:0]                rd_data_o,
    output logic                                 rd_err_o
);

    localparam int TAG_DEPTH = RD_LAT + 2;

    logic [NUM_PORTS-1:0]  wr_gnt, rd_gnt;
    logic                  rd_en;
    logic                  tag_full, tag_empty, tag_push, tag_pop;
    port_idx_t             rd_gnt_idx, tag_head;
    logic [ADDR_W-1:0]     wr_addr_sel, rd_addr_sel;
    logic [BLOCK_BITS-1:0] wr_data_sel;

    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_waddr_q;
    logic [BLOCK_BITS-1:0] mem_wdata_q;
    logic                  mem_re_q;
    logic [ADDR_W-1:0]     mem_raddr_q;
    logic [NUM_PORTS-1:0]  rd_valid_q;
    logic [BLOCK_BITS-1:0] rd_data_q;
    logic                  rd_err_q;

    wrr_sel #(
        .NUM_PORTS (NUM_PORTS),
        .WEIGHT_W  (WEIGHT_W)
    ) u_wr_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (1'b1),
        .req_i    (wr_req_i),
        .weight_i (wr_weight_i),
        .gnt_o    (wr_gnt)
    );

    wrr_sel #(
        .NUM_PORTS (NUM_PORTS),
        .WEIGHT_W  (WEIGHT_W)
    ) u_rd_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (rd_en),
        .req_i    (rd_req_i),
        .weight_i (rd_weight_i),
        .gnt_o    (rd_gnt)
    );

    // Full FIFO blocks read grants outright, even when a pop lands in the same cycle.
    assign rd_en    = !tag_full;
    assign tag_push = |rd_gnt;
    assign tag_pop  = mem_rvalid_i && !tag_empty;

    sync_fifo #(
        .WIDTH (PORT_IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (tag_push),
        .push_dat_i (rd_gnt_idx),
        .pop_i      (tag_pop),
        .head_dat_o (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    // Steer the one-hot granted port's address, data and index onto the shared buses.
    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        rd_gnt_idx  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_gnt[p]) begin
                wr_addr_sel = wr_addr_i[p];
                wr_data_sel = wr_data_i[p];
            end
            if (rd_gnt[p]) begin
                rd_addr_sel = rd_addr_i[p];
                rd_gnt_idx  = port_idx_t'(p);
            end
        end
    end

    // Register the SRAM command for both channels one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
        end else begin
            mem_we_q <= |wr_gnt;
            mem_re_q <= |rd_gnt;
            if (|wr_gnt) begin
                mem_waddr_q <= wr_addr_sel;
                mem_wdata_q <= wr_data_sel;
            end
            if (|rd_gnt) begin
                mem_raddr_q <= rd_addr_sel;
            end
        end
    end

    // Return path: deliver data to the tagged port; data with no tag outstanding sets a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= tag_pop ? (NUM_PORTS'(1) << tag_head) : '0;
            if (tag_pop) begin
                rd_data_q <= mem_rdata_i;
            end
            if (mem_rvalid_i && tag_empty) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign wr_gnt_o    = wr_gnt;
    assign rd_gnt_o    = rd_gnt;
    assign mem_we_o    = mem_we_q;
    assign mem_waddr_o = mem_waddr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_re_o    = mem_re_q;
    assign mem_raddr_o = mem_raddr_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_err_o    = rd_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A (RD_LAT=2) with an SRAM model, instance B (RD_LAT=1) with manual rvalid.
// Inputs change 1 unit after the rising edge; outputs sampled a unit later.
// Expected values are hand-derived constants and tables.
module tb_mem_port_arbiter;
    import mem_pkg::*;
    import switch_pkg::*;

    localparam int NP = 4;
    localparam int WW = WEIGHT_W_DEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NP-1:0][WW-1:0]         wr_weight, rd_weight;
    logic [NP-1:0]                 wr_req, rd_req;
    logic [NP-1:0][ADDR_W-1:0]     wr_addr, rd_addr;
    logic [NP-1:0][BLOCK_BITS-1:0] wr_data;

    logic [NP-1:0]         a_wr_gnt, a_rd_gnt, a_rd_valid;
    logic                  a_mem_we, a_mem_re, a_mem_rvalid, a_rd_err;
    logic [ADDR_W-1:0]     a_mem_waddr, a_mem_raddr;
    logic [BLOCK_BITS-1:0] a_mem_wdata, a_mem_rdata, a_rd_data;

    logic [NP-1:0]         b_wr_gnt, b_rd_gnt, b_rd_valid;
    logic                  b_mem_we, b_mem_re, b_rd_err;
    logic [ADDR_W-1:0]     b_mem_waddr, b_mem_raddr;
    logic [BLOCK_BITS-1:0] b_mem_wdata, b_rd_data;

    logic                  rv_force_a;
    logic                  rv_b;
    logic [BLOCK_BITS-1:0] rd_b;

    logic [1:0]            re_pipe;
    logic [ADDR_W-1:0]     ra_pipe0, ra_pipe1;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.NUM_PORTS(NP), .RD_LAT(2), .WEIGHT_W(WW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_weight_i(wr_weight), .rd_weight_i(rd_weight),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(a_wr_gnt),
        .mem_we_o(a_mem_we), .mem_waddr_o(a_mem_waddr), .mem_wdata_o(a_mem_wdata),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(a_rd_gnt),
        .mem_re_o(a_mem_re), .mem_raddr_o(a_mem_raddr),
        .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(a_mem_rdata),
        .rd_valid_o(a_rd_valid), .rd_data_o(a_rd_data), .rd_err_o(a_rd_err)
    );

    mem_port_arbiter #(.NUM_PORTS(NP), .RD_LAT(1), .WEIGHT_W(WW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_weight_i(wr_weight), .rd_weight_i(rd_weight),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(b_wr_gnt),
        .mem_we_o(b_mem_we), .mem_waddr_o(b_mem_waddr), .mem_wdata_o(b_mem_wdata),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(b_rd_gnt),
        .mem_re_o(b_mem_re), .mem_raddr_o(b_mem_raddr),
        .mem_rvalid_i(rv_b), .mem_rdata_i(rd_b),
        .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data), .rd_err_o(b_rd_err)
    );

    // Two-cycle SRAM model for instance A; shares rst_n with the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_pipe  <= '0;
            ra_pipe0 <= '0;
            ra_pipe1 <= '0;
        end else begin
            re_pipe  <= {re_pipe[0], a_mem_re};
            ra_pipe0 <= a_mem_raddr;
            ra_pipe1 <= ra_pipe0;
        end
    end
    assign a_mem_rvalid = re_pipe[1] | rv_force_a;
    assign a_mem_rdata  = 32'hC0DE_0000 | BLOCK_BITS'(ra_pipe1);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        wr_req     = '0;
        rd_req     = '0;
        rv_force_a = 1'b0;
        rv_b       = 1'b0;
        rd_b       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int exp_w [7] = '{0, 0, 1, 2, 3, 0, 0};
    int exp_z [4] = '{0, 1, 0, 1};

    initial begin
        rst_n = 1'b0;
        wr_weight = '0;
        rd_weight = '0;
        for (int p = 0; p < NP; p++) begin
            wr_addr[p] = ADDR_W'(16 + p);
            wr_data[p] = 32'hA000_0000 + BLOCK_BITS'(p);
            rd_addr[p] = ADDR_W'(64 + p);
        end

        // Reset state
        do_reset();
        check_eq("rst_mem_we",   a_mem_we,    0);
        check_eq("rst_mem_re",   a_mem_re,    0);
        check_eq("rst_waddr",    a_mem_waddr, 0);
        check_eq("rst_rd_valid", a_rd_valid,  0);
        check_eq("rst_rd_data",  a_rd_data,   0);
        check_eq("rst_rd_err",   a_rd_err,    0);
        check_eq("rst_wr_gnt",   a_wr_gnt,    0);

        // Weights {2,1,1,1}, all write requests high
        wr_weight[0] = 4'd2; wr_weight[1] = 4'd1; wr_weight[2] = 4'd1; wr_weight[3] = 4'd1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_req = 4'hF;
            #1;
            check_eq($sformatf("wrr_gnt_%0d", i), a_wr_gnt, 64'(1) << exp_w[i]);
            step();
            check_eq($sformatf("wrr_we_%0d", i), a_mem_we, 1);
            check_eq($sformatf("wrr_waddr_%0d", i), a_mem_waddr, 64'(16 + exp_w[i]));
            check_eq($sformatf("wrr_wdata_%0d", i), a_mem_wdata, 64'h0A000_0000 + 64'(exp_w[i]));
        end
        wr_req = '0;
        #1;
        check_eq("wrr_idle_gnt", a_wr_gnt, 0);
        step();
        check_eq("wrr_idle_we", a_mem_we, 0);

        // Lone requester with weight 3 keeps winning across credit reload
        wr_weight = '0;
        wr_weight[2] = 4'd3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_req = 4'b0100;
            #1;
            check_eq($sformatf("solo_gnt_%0d", i), a_wr_gnt, 4'b0100);
            step();
        end
        wr_req = '0;

        // Zero weights behave as weight 1
        wr_weight = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_req = 4'b0011;
            #1;
            check_eq($sformatf("w0_gnt_%0d", i), a_wr_gnt, 64'(1) << exp_z[i]);
            step();
        end
        wr_req = '0;

        // RD_LAT=2: reads by port 1 then port 3, data 4 cycles after grant
        for (int p = 0; p < NP; p++) rd_weight[p] = 4'd1;
        do_reset();
        rd_req = 4'b0010;
        #1;
        check_eq("rd_gnt_p1", a_rd_gnt, 4'b0010);
        step();
        check_eq("rd_re_p1",    a_mem_re,    1);
        check_eq("rd_raddr_p1", a_mem_raddr, 10'h041);
        rd_req = 4'b1000;
        #1;
        check_eq("rd_gnt_p3", a_rd_gnt, 4'b1000);
        step();
        check_eq("rd_raddr_p3", a_mem_raddr, 10'h043);
        rd_req = '0;
        check_eq("rd_valid_t2", a_rd_valid, 0);
        step();
        check_eq("rd_valid_t3", a_rd_valid, 0);
        step();
        check_eq("rd_valid_p1", a_rd_valid, 4'b0010);
        check_eq("rd_data_p1",  a_rd_data,  32'hC0DE_0041);
        step();
        check_eq("rd_valid_p3", a_rd_valid, 4'b1000);
        check_eq("rd_data_p3",  a_rd_data,  32'hC0DE_0043);
        step();
        check_eq("rd_valid_t6", a_rd_valid, 0);
        check_eq("rd_err_ok",   a_rd_err,   0);

        // RD_LAT=1 with stalled rvalid: 3 outstanding then blocked until a pop
        do_reset();
        rd_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("full_gnt_%0d", i), b_rd_gnt, 4'b0001);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("full_block_%0d", i), b_rd_gnt, 0);
            step();
        end
        rv_b = 1'b1;
        rd_b = 32'h5555_AAAA;
        #1;
        check_eq("full_pop_same_cycle", b_rd_gnt, 0);
        step();
        rv_b = 1'b0;
        check_eq("full_pop_valid", b_rd_valid, 4'b0001);
        check_eq("full_pop_data",  b_rd_data,  32'h5555_AAAA);
        #1;
        check_eq("full_after_pop", b_rd_gnt, 4'b0001);
        step();
        #1;
        check_eq("full_again", b_rd_gnt, 0);
        rd_req = '0;
        step();

        // Orphan rvalid sets sticky error, no data delivered
        do_reset();
        rv_force_a = 1'b1;
        step();
        rv_force_a = 1'b0;
        check_eq("orphan_err",   a_rd_err,   1);
        check_eq("orphan_valid", a_rd_valid, 0);
        repeat (3) step();
        check_eq("orphan_err_sticky",   a_rd_err,   1);
        check_eq("orphan_valid_later",  a_rd_valid, 0);

        // Reset with 2 reads outstanding (ports 2,3); post-reset port 0 read returns to port 0
        do_reset();
        rd_req = 4'b0100;
        #1;
        check_eq("mid_gnt_p2", a_rd_gnt, 4'b0100);
        step();
        rd_req = 4'b1000;
        step();
        rd_req = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_re",    a_mem_re,   0);
        check_eq("mid_rst_we",    a_mem_we,   0);
        check_eq("mid_rst_raddr", a_mem_raddr, 0);
        check_eq("mid_rst_valid", a_rd_valid, 0);
        check_eq("mid_rst_err",   a_rd_err,   0);
        step();
        step();
        rst_n = 1'b1;
        rd_req = 4'b0001;
        #1;
        check_eq("post_rst_gnt", a_rd_gnt, 4'b0001);
        step();
        rd_req = '0;
        check_eq("post_rst_t1", a_rd_valid, 0);
        step();
        check_eq("post_rst_t2", a_rd_valid, 0);
        step();
        check_eq("post_rst_t3", a_rd_valid, 0);
        step();
        check_eq("post_rst_valid", a_rd_valid, 4'b0001);
        check_eq("post_rst_data",  a_rd_data,  32'hC0DE_0040);
        check_eq("post_rst_err",   a_rd_err,   0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
